// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module     : serial_frame_pkg
// Description: Shared types and constants for the serial frame controller.
//              Holds the controller state encoding, the default field widths
//              and the frame header length.
// Revision   : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

  // Default field widths: port-number field and payload-length field.
  localparam int PORT_W_DEF = 2;
  localparam int CNT_W_DEF  = 4;

  // Header = start bit + port field + length field.
  function automatic int frame_hdr_len(input int pw, input int cw);
    return 1 + pw + cw;
  endfunction

  localparam int HDR_LEN = frame_hdr_len(PORT_W_DEF, CNT_W_DEF);

  // Controller states. PARITY is reachable only when the parity check is
  // built in.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_PORT = 3'd1,
    GET_CNT  = 3'd2,
    SEND     = 3'd3,
    PARITY   = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_frame_ser_shift_in.sv
`default_nettype none
// ============================================================================
// Module     : ser_shift_in
// Description: MSB-first serial-to-parallel shift register with shift enable.
//              Each enabled cycle shifts the register left by one and inserts
//              i_bit at the LSB, so the first bit received ends up as MSB.
// Revision   : 1.0 - initial release
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      synchronous active-low reset (clears the register)
//   i_en   in   1      shift enable
//   i_bit  in   1      serial bit to insert at the LSB
//   o_data out  WIDTH  current register contents
// ============================================================================
module ser_shift_in
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = PORT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  generate
    if (WIDTH == 1) begin : g_single
      // A one-bit field is just a load-enabled flop.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data <= '0;
        end else if (i_en) begin
          r_data <= i_bit;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data <= '0;
        end else if (i_en) begin
          r_data <= {r_data[WIDTH-2:0], i_bit};
        end
      end
    end
  endgenerate

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : serial_frame_ctrl
// Description: Frame controller for a 1-to-N serial port demultiplexer.
//              Parses ser_in frames of the form
//                start(0) | port[PORT_W] | length[CNT_W] | payload[length]
//              (fields MSB-first), drives the demux select during the
//              payload and qualifies each payload bit with data_valid.
//              Optional build macro: PARITY_CHECK_EN
//                defined   - one even-parity bit follows the payload; a
//                            mismatch raises err together with done.
//                undefined - no parity bit, err is tied low.
// Revision   : 1.0 - initial release
//
// Ports:
//   clk        in   1       clock, all state updates on rising edge
//   rst_n      in   1       synchronous active-low reset
//   ser_in     in   1       serial frame input
//   port_num   out  PORT_W  demux select (captured port field)
//   ser_out    out  1       payload bit to demux (ser_in during SEND, else 0)
//   data_valid out  1       high exactly during payload bit cycles
//   busy       out  1       high in every state except IDLE
//   done       out  1       one-cycle pulse in the DONE state
//   err        out  1       one-cycle parity-error pulse, coincident with done
// ============================================================================
module serial_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter int PORT_W = PORT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  output logic [PORT_W-1:0] port_num,
  output logic              ser_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Bit counter must index the longer of the two header fields.
  localparam int MAX_FIELD_W = (PORT_W > CNT_W) ? PORT_W : CNT_W;
  localparam int BIT_W       = $clog2(MAX_FIELD_W + 1);

  localparam logic [BIT_W-1:0] c_port_last = BIT_W'(PORT_W - 1);
  localparam logic [BIT_W-1:0] c_cnt_last  = BIT_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  // State entered once the payload has been consumed.
`ifdef PARITY_CHECK_EN
  localparam state_t c_post_payload = PARITY;
`else
  localparam state_t c_post_payload = DONE;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_full;
  logic [PORT_W-1:0] w_port;
  logic             w_port_en;
  logic             w_cnt_en;
  logic             w_cnt_last;
  logic             r_done;
  logic             r_err;
  // The length register MSB shifts out on the final length bit; the
  // decision uses the assembled value instead.
  logic             w_unused_cnt_msb;

  // --------------------------------------------------------------------------
  // Header field capture
  // --------------------------------------------------------------------------
  assign w_port_en = (r_state == GET_PORT);
  assign w_cnt_en  = (r_state == GET_CNT);

  ser_shift_in #(
    .WIDTH (PORT_W)
  ) u_port_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_port_en),
    .i_bit  (ser_in),
    .o_data (w_port)
  );

  ser_shift_in #(
    .WIDTH (CNT_W)
  ) u_cnt_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_cnt_en),
    .i_bit  (ser_in),
    .o_data (w_count)
  );

  // On the last length bit the register does not yet hold it, so the full
  // length is assembled from the stored bits plus the live input.
  assign w_cnt_full       = {w_count[CNT_W-2:0], ser_in};
  assign w_cnt_last       = w_cnt_en && (r_bit_cnt == c_cnt_last);
  assign w_unused_cnt_msb = w_count[CNT_W-1];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!ser_in) begin
          w_state_nxt = GET_PORT;
        end
      end
      GET_PORT: begin
        if (r_bit_cnt == c_port_last) begin
          w_state_nxt = GET_CNT;
        end
      end
      GET_CNT: begin
        if (w_cnt_last) begin
          w_state_nxt = (w_cnt_full == '0) ? c_post_payload : SEND;
        end
      end
      SEND: begin
        if (r_remaining == c_one) begin
          w_state_nxt = c_post_payload;
        end
      end
      PARITY:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Field bit counter and payload down-counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (r_state != w_state_nxt) begin
      r_bit_cnt <= '0;
    end else if ((r_state == GET_PORT) || (r_state == GET_CNT)) begin
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining <= '0;
    end else if (w_cnt_last) begin
      r_remaining <= w_cnt_full;
    end else if ((r_state == SEND) && (r_remaining > c_one)) begin
      // Floor at 1: the exit condition is remaining == 1.
      r_remaining <= r_remaining - c_one;
    end
  end

  // --------------------------------------------------------------------------
  // Frame-end pulses. Registered on entry to DONE so they are high for the
  // whole DONE cycle.
  // --------------------------------------------------------------------------
`ifdef PARITY_CHECK_EN
  logic r_par;

  // Running XOR of payload bits, cleared as the start bit is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if ((r_state == IDLE) && !ser_in) begin
      r_par <= 1'b0;
    end else if (r_state == SEND) begin
      r_par <= r_par ^ ser_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == PARITY) && (r_par ^ ser_in);
    end
  end
`else
  assign r_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign port_num   = w_port;
  assign busy       = (r_state != IDLE);
  assign data_valid = (r_state == SEND);
  assign ser_out    = data_valid & ser_in;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire
